// File: rtl/display_scan_ctrl_pkg.sv
// ============================================================================
//  display_scan_ctrl_pkg
//  Shared types and constants for the seven-segment scan scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package display_scan_ctrl_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic [31:0] ANODE_OFF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Bits needed to hold value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_scan_timer.sv
// ============================================================================
//  display_scan_ctrl_scan_timer
//  Phase down-counter: loaded with (phase length - 1), flags the last cycle.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl_scan_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_phase_end
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_phase_end = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
//  display_scan_ctrl
//  Multiplexed 7-seg scan scheduler with blanking dead time, double-buffered
//  digit data committed at frame boundaries, and leading-zero suppression.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in,
    input  logic                           load,
    input  logic [NUM_DIGITS-1:0]          digit_mask,
    input  logic                           lz_suppress,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [NIBBLE_W-1:0]            bcd_out,
    output logic                           blank,
    output logic                           frame_done,
    output logic                           load_ack
);

    localparam int c_DATA_W  = NIBBLE_W * NUM_DIGITS;
    localparam int c_IDX_W   = clog2(NUM_DIGITS);
    localparam int c_MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W   = clog2(c_MAX_CYC);

    localparam logic [c_CNT_W-1:0]    c_DWELL_LOAD = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_BLANK_LOAD = c_CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF     = ANODE_OFF[NUM_DIGITS-1:0];
    // With no dead time every slot starts directly in SHOW.
    localparam scan_state_t           c_SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    scan_state_t             r_state, w_state_nxt;
    logic [c_IDX_W-1:0]      r_index, w_index_nxt;
    logic [c_DATA_W-1:0]     r_active, r_pend, w_active_nxt;
    logic                    r_pend_valid;
    logic                    w_wrap, w_commit, w_phase_end, w_timer_load, w_above_zero;
    logic [c_CNT_W-1:0]      w_timer_val;
    logic [NUM_DIGITS-1:0]   w_visible, w_an_nxt;
    logic [NIBBLE_W-1:0]     w_bcd_nxt;
    logic                    w_blank_nxt;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [NIBBLE_W-1:0]     r_bcd;
    logic                    r_blank, r_frame_done, r_load_ack;

    display_scan_ctrl_scan_timer #(
        .CNT_W (c_CNT_W)
    ) u_timer (
        .clk         (clock),
        .rst         (reset),
        .i_clear     (!enable),
        .i_load      (w_timer_load),
        .i_load_val  (w_timer_val),
        .o_phase_end (w_phase_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_wrap      = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_index_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = c_SLOT_START;
                    w_index_nxt = '0;
                end
                ST_BLANK: begin
                    if (w_phase_end) begin
                        w_state_nxt = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (w_phase_end) begin
                        w_state_nxt = c_SLOT_START;
                        if (r_index == c_LAST_IDX) begin
                            w_index_nxt = '0;
                            w_wrap      = 1'b1;
                        end else begin
                            w_index_nxt = r_index + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_timer_load = (w_state_nxt != ST_IDLE) && ((r_state == ST_IDLE) || w_phase_end);
    assign w_timer_val  = (w_state_nxt == ST_SHOW) ? c_DWELL_LOAD : c_BLANK_LOAD;

    // A load landing on the commit cycle bypasses the pending buffer.
    assign w_commit     = ((r_state == ST_IDLE) || w_wrap) && (r_pend_valid || load);
    assign w_active_nxt = w_commit ? (load ? digits_in : r_pend) : r_active;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_active     <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            if (w_commit) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend       <= digits_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Scan from the top digit down; w_above_zero tracks "no used nonzero digit above".
    always_comb begin
        w_above_zero = 1'b1;
        w_visible    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_visible[i] = digit_mask[i] &&
                           !(lz_suppress && (i != 0) && w_above_zero &&
                             (w_active_nxt[i*NIBBLE_W +: NIBBLE_W] == '0));
            if (digit_mask[i] && (w_active_nxt[i*NIBBLE_W +: NIBBLE_W] != '0)) begin
                w_above_zero = 1'b0;
            end
        end
    end

    always_comb begin
        w_an_nxt    = c_AN_OFF;
        w_bcd_nxt   = '0;
        w_blank_nxt = 1'b1;
        if ((w_state_nxt == ST_SHOW) && w_visible[w_index_nxt]) begin
            w_an_nxt[w_index_nxt] = 1'b0;
            w_bcd_nxt             = w_active_nxt[w_index_nxt*NIBBLE_W +: NIBBLE_W];
            w_blank_nxt           = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_an         <= c_AN_OFF;
            r_bcd        <= '0;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
            r_load_ack   <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_bcd        <= w_bcd_nxt;
            r_blank      <= w_blank_nxt;
            r_frame_done <= w_wrap;
            r_load_ack   <= w_commit;
        end
    end

    assign an         = r_an;
    assign bcd_out    = r_bcd;
    assign blank      = r_blank;
    assign frame_done = r_frame_done;
    assign load_ack   = r_load_ack;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
//  tb_display_scan_ctrl
//  Self-checking bench: time-slot reference model plus directed scenarios.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

    localparam int N     = 8;
    localparam int D     = 4;
    localparam int B     = 2;
    localparam int SLOT  = B + D;
    localparam int FRAME = N * SLOT;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [31:0] digits_in = '0;
    logic [7:0]  digit_mask = 8'hFF;
    logic [7:0]  an;
    logic [3:0]  bcd_out;
    logic        blank, frame_done, load_ack;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    display_scan_ctrl #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .digits_in   (digits_in),
        .load        (load),
        .digit_mask  (digit_mask),
        .lz_suppress (lz_suppress),
        .an          (an),
        .bcd_out     (bcd_out),
        .blank       (blank),
        .frame_done  (frame_done),
        .load_ack    (load_ack)
    );

    // Reference model: scan position is elapsed cycles since enable, sliced into slots.
    logic [31:0] m_active, m_pend;
    bit          m_pvalid, m_run;
    int          m_t;
    logic [7:0]  e_an;
    logic [3:0]  e_bcd;
    logic        e_blank, e_fd, e_ack;

    function automatic bit m_vis(input logic [31:0] act, input logic [7:0] mask,
                                 input logic lz, input int i);
        logic [31:0] a;
        int          h;
        a = act;
        h = -1;
        for (int j = 0; j < N; j++) begin
            if (mask[j] && (a[j*4 +: 4] != 4'h0)) h = j;
        end
        return mask[i] && (!lz || i == 0 || a[i*4 +: 4] != 4'h0 || i < h);
    endfunction

    always @(posedge clock) begin
        bit wrap, commit;
        int pos;
        if (reset) begin
            m_active = '0; m_pend = '0; m_pvalid = 0; m_run = 0; m_t = 0;
            e_an = 8'hFF; e_bcd = 4'h0; e_blank = 1'b1; e_fd = 1'b0; e_ack = 1'b0;
        end else begin
            wrap   = m_run && enable && (m_t % FRAME == FRAME - 1);
            commit = (!m_run || wrap) && (m_pvalid || load);
            if (commit) begin
                m_active = load ? digits_in : m_pend;
                m_pvalid = 0;
            end else if (load) begin
                m_pend   = digits_in;
                m_pvalid = 1;
            end
            e_fd  = wrap;
            e_ack = commit;
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t++;
            end
            e_an = 8'hFF; e_bcd = 4'h0; e_blank = 1'b1;
            if (m_run) begin
                pos = m_t % FRAME;
                if ((pos % SLOT) >= B && m_vis(m_active, digit_mask, lz_suppress, pos / SLOT)) begin
                    e_an[pos / SLOT] = 1'b0;
                    e_bcd            = m_active[(pos / SLOT)*4 +: 4];
                    e_blank          = 1'b0;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h want ff", an); end
        checks++; if (bcd_out !== 4'h0) begin errors++; $display("FAIL reset_bcd: got %h want 0", bcd_out); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b want 1", blank); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", load_ack); end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        int fd_cnt = 0;
        int fd_first = -1;
        digits_in = 32'h8765_4321; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL scan_idle_ack: got %b want 1", load_ack); end
        enable = 1'b1;
        for (int t = 0; t <= 96; t++) begin
            @(negedge clock);
            checks++;
            if ({an, bcd_out, blank, frame_done, load_ack} !== {e_an, e_bcd, e_blank, e_fd, e_ack}) begin
                errors++;
                $display("FAIL scan t=%0d: an=%h bcd=%h blank=%b fd=%b ack=%b want an=%h bcd=%h blank=%b fd=%b ack=%b",
                         t, an, bcd_out, blank, frame_done, load_ack, e_an, e_bcd, e_blank, e_fd, e_ack);
            end
            if (frame_done) begin fd_cnt++; if (fd_first < 0) fd_first = t; end
            if (t == 0) begin checks++; if (an !== 8'hFF || blank !== 1'b1) begin errors++; $display("FAIL scan_blank0: an=%h blank=%b want ff 1", an, blank); end end
            if (t == 2) begin checks++; if (an !== 8'hFE || bcd_out !== 4'h1) begin errors++; $display("FAIL scan_d0: an=%h bcd=%h want fe 1", an, bcd_out); end end
            if (t == 8) begin checks++; if (an !== 8'hFD || bcd_out !== 4'h2) begin errors++; $display("FAIL scan_d1: an=%h bcd=%h want fd 2", an, bcd_out); end end
            if (t == 44) begin checks++; if (an !== 8'h7F || bcd_out !== 4'h8) begin errors++; $display("FAIL scan_d7: an=%h bcd=%h want 7f 8", an, bcd_out); end end
        end
        checks++; if (fd_cnt != 2) begin errors++; $display("FAIL scan_fd_count: got %0d want 2", fd_cnt); end
        checks++; if (fd_first != 48) begin errors++; $display("FAIL scan_fd_first: got %0d want 48", fd_first); end
    endtask

    task automatic test_midframe_load();
        int acks = 0;
        for (int t = 97; t <= 160; t++) begin
            @(negedge clock);
            checks++;
            if ({an, bcd_out, blank, frame_done, load_ack} !== {e_an, e_bcd, e_blank, e_fd, e_ack}) begin
                errors++;
                $display("FAIL midload t=%0d: an=%h bcd=%h blank=%b fd=%b ack=%b want an=%h bcd=%h blank=%b fd=%b ack=%b",
                         t, an, bcd_out, blank, frame_done, load_ack, e_an, e_bcd, e_blank, e_fd, e_ack);
            end
            if (load_ack) acks++;
            if (t == 117) begin checks++; if (an !== 8'hF7 || bcd_out !== 4'h4) begin errors++; $display("FAIL midload_hold: an=%h bcd=%h want f7 4", an, bcd_out); end end
            if (t == 144) begin checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL midload_ack: got %b want 1", load_ack); end end
            if (t == 146) begin checks++; if (an !== 8'hFE || bcd_out !== 4'h9) begin errors++; $display("FAIL midload_d0: an=%h bcd=%h want fe 9", an, bcd_out); end end
            if (t == 152) begin checks++; if (an !== 8'hFD || bcd_out !== 4'h9) begin errors++; $display("FAIL midload_d1: an=%h bcd=%h want fd 9", an, bcd_out); end end
            if (t == 158) begin checks++; if (an !== 8'hFB || bcd_out !== 4'h0) begin errors++; $display("FAIL midload_d2: an=%h bcd=%h want fb 0", an, bcd_out); end end
            load = (t == 116);
            if (t == 116) digits_in = 32'h0000_0099;
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL midload_ack_count: got %0d want 1", acks); end
    endtask

    task automatic test_lz_suppress();
        enable = 1'b0; digits_in = 32'h0000_0105; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        @(negedge clock);
        enable = 1'b1; lz_suppress = 1'b1;
        for (int t = 0; t <= 60; t++) begin
            @(negedge clock);
            checks++;
            if ({an, bcd_out, blank, frame_done, load_ack} !== {e_an, e_bcd, e_blank, e_fd, e_ack}) begin
                errors++;
                $display("FAIL lz t=%0d: an=%h bcd=%h blank=%b fd=%b ack=%b want an=%h bcd=%h blank=%b fd=%b ack=%b",
                         t, an, bcd_out, blank, frame_done, load_ack, e_an, e_bcd, e_blank, e_fd, e_ack);
            end
            if (t == 2) begin checks++; if (an !== 8'hFE || bcd_out !== 4'h5) begin errors++; $display("FAIL lz_d0: an=%h bcd=%h want fe 5", an, bcd_out); end end
            if (t == 8) begin checks++; if (an !== 8'hFD || bcd_out !== 4'h0 || blank !== 1'b0) begin errors++; $display("FAIL lz_d1: an=%h bcd=%h blank=%b want fd 0 0", an, bcd_out, blank); end end
            if (t == 14) begin checks++; if (an !== 8'hFB || bcd_out !== 4'h1) begin errors++; $display("FAIL lz_d2: an=%h bcd=%h want fb 1", an, bcd_out); end end
            if (t == 20 || t == 44) begin checks++; if (an !== 8'hFF || blank !== 1'b1 || bcd_out !== 4'h0) begin errors++; $display("FAIL lz_sup t=%0d: an=%h blank=%b bcd=%h want ff 1 0", t, an, blank, bcd_out); end end
            if (t == 50) begin checks++; if (an !== 8'hFE || bcd_out !== 4'h0 || blank !== 1'b0) begin errors++; $display("FAIL lz_zero_d0: an=%h bcd=%h blank=%b want fe 0 0", an, bcd_out, blank); end end
            if (t == 56) begin checks++; if (an !== 8'hFF || blank !== 1'b1) begin errors++; $display("FAIL lz_zero_d1: an=%h blank=%b want ff 1", an, blank); end end
            load = (t == 30);
            if (t == 30) digits_in = 32'h0;
        end
    endtask

    task automatic test_mask();
        int bad_an = 0;
        int fd_cnt = 0;
        int fd_last = -1;
        enable = 1'b0; lz_suppress = 1'b0; digits_in = 32'h0000_4321; load = 1'b1;
        @(negedge clock);
        load = 1'b0; digit_mask = 8'h03;
        @(negedge clock);
        enable = 1'b1;
        for (int t = 0; t <= 96; t++) begin
            @(negedge clock);
            checks++;
            if ({an, bcd_out, blank, frame_done, load_ack} !== {e_an, e_bcd, e_blank, e_fd, e_ack}) begin
                errors++;
                $display("FAIL mask t=%0d: an=%h bcd=%h blank=%b fd=%b ack=%b want an=%h bcd=%h blank=%b fd=%b ack=%b",
                         t, an, bcd_out, blank, frame_done, load_ack, e_an, e_bcd, e_blank, e_fd, e_ack);
            end
            if (an !== 8'hFF && an !== 8'hFE && an !== 8'hFD) bad_an++;
            if (frame_done) begin fd_cnt++; fd_last = t; end
            if (t == 8) begin checks++; if (an !== 8'hFD || bcd_out !== 4'h2) begin errors++; $display("FAIL mask_d1: an=%h bcd=%h want fd 2", an, bcd_out); end end
            if (t == 20) begin checks++; if (an !== 8'hFF || blank !== 1'b1) begin errors++; $display("FAIL mask_d3: an=%h blank=%b want ff 1", an, blank); end end
        end
        checks++; if (bad_an != 0) begin errors++; $display("FAIL mask_anodes: got %0d bad cycles want 0", bad_an); end
        checks++; if (fd_cnt != 2 || fd_last != 96) begin errors++; $display("FAIL mask_frame: got %0d pulses last=%0d want 2 last=96", fd_cnt, fd_last); end
        digit_mask = 8'hFF;
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        for (int t = 0; t <= 33; t++) begin
            @(negedge clock);
            checks++;
            if ({an, bcd_out, blank, frame_done, load_ack} !== {e_an, e_bcd, e_blank, e_fd, e_ack}) begin
                errors++;
                $display("FAIL endrop t=%0d: an=%h bcd=%h blank=%b fd=%b ack=%b want an=%h bcd=%h blank=%b fd=%b ack=%b",
                         t, an, bcd_out, blank, frame_done, load_ack, e_an, e_bcd, e_blank, e_fd, e_ack);
            end
            if (t == 32) begin load = 1'b1; digits_in = 32'h0000_1234; end
            if (t == 33) begin
                checks++; if (an !== 8'hDF || bcd_out !== 4'h0) begin errors++; $display("FAIL endrop_d5: an=%h bcd=%h want df 0", an, bcd_out); end
                load = 1'b0; enable = 1'b0;
            end
        end
        @(negedge clock);
        checks++; if (an !== 8'hFF || blank !== 1'b1 || load_ack !== 1'b0) begin errors++; $display("FAIL endrop_dark: an=%h blank=%b ack=%b want ff 1 0", an, blank, load_ack); end
        @(negedge clock);
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL endrop_ack: got %b want 1", load_ack); end
        enable = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            @(negedge clock);
            if (t == 0) begin checks++; if (an !== 8'hFF || blank !== 1'b1) begin errors++; $display("FAIL endrop_restart_blank: an=%h blank=%b want ff 1", an, blank); end end
            if (t == 2) begin checks++; if (an !== 8'hFE || bcd_out !== 4'h4) begin errors++; $display("FAIL endrop_restart_d0: an=%h bcd=%h want fe 4", an, bcd_out); end end
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        for (int t = 0; t <= 3; t++) begin
            @(negedge clock);
            if (t == 3) begin load = 1'b1; digits_in = 32'h0000_5555; end
        end
        @(negedge clock);
        load = 1'b0; reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({an, bcd_out, blank, frame_done, load_ack} !== {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_values: an=%h bcd=%h blank=%b fd=%b ack=%b want ff 0 1 0 0", an, bcd_out, blank, frame_done, load_ack);
        end
        reset = 1'b0;
        for (int t = 0; t <= 20; t++) begin
            @(negedge clock);
            checks++;
            if ({an, bcd_out, blank, frame_done, load_ack} !== {e_an, e_bcd, e_blank, e_fd, e_ack}) begin
                errors++;
                $display("FAIL rstmid t=%0d: an=%h bcd=%h blank=%b fd=%b ack=%b want an=%h bcd=%h blank=%b fd=%b ack=%b",
                         t, an, bcd_out, blank, frame_done, load_ack, e_an, e_bcd, e_blank, e_fd, e_ack);
            end
            if (load_ack) acks++;
            if (t == 2) begin checks++; if (an !== 8'hFE || bcd_out !== 4'h0) begin errors++; $display("FAIL rstmid_d0: an=%h bcd=%h want fe 0", an, bcd_out); end end
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL rstmid_no_ack: got %0d acks want 0", acks); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        lz_suppress = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            checks++;
            if ({an, bcd_out, blank, frame_done, load_ack} !== {e_an, e_bcd, e_blank, e_fd, e_ack}) begin
                errors++;
                $display("FAIL random c=%0d: an=%h bcd=%h blank=%b fd=%b ack=%b want an=%h bcd=%h blank=%b fd=%b ack=%b",
                         c, an, bcd_out, blank, frame_done, load_ack, e_an, e_bcd, e_blank, e_fd, e_ack);
            end
            reset = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 7) == 0);
            d = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0) d[i*4 +: 4] = 4'($urandom_range(0, 15));
            end
            digits_in = d;
            if (enable) enable = ($urandom_range(0, 199) != 0);
            else        enable = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) digit_mask = 8'($urandom);
            if ($urandom_range(0, 99) == 0) lz_suppress = 1'($urandom_range(0, 1));
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_lz_suppress();
        test_mask();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
